// File: rtl/vec_sram_loader.sv
// vec_sram_loader: streams packed 32-bit words (4 x 8-bit elements, little-endian)
// into vector SRAM, one element per cycle, at addresses 0..n-1.
// done stays high after a load until the next accepted start or reset.
module vec_sram_loader #(
  parameter int SRAM_ADDR_WIDTH = 10,
  parameter int MAX_DIM         = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  input  logic [7:0]                 len,
  input  logic [31:0]                in_data,
  input  logic                       in_valid,
  output logic                       in_ready,
  output logic                       sram_we,
  output logic [SRAM_ADDR_WIDTH-1:0] sram_addr,
  output logic [7:0]                 sram_din,
  output logic                       busy,
  output logic                       done
);

  localparam logic [7:0] MAX_N = 8'(MAX_DIM);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCEPT = 2'd1,
    S_UNPACK = 2'd2,
    S_DONE   = 2'd3
  } state_t;

  state_t                     r_state;
  state_t                     w_state_next;

  logic [7:0]                 r_n;
  logic [7:0]                 r_cnt;
  logic [1:0]                 r_bidx;
  logic [31:0]                r_wbuf;
  logic                       r_we;
  logic [SRAM_ADDR_WIDTH-1:0] r_addr;
  logic [7:0]                 r_din;

  logic [7:0]                 w_n;
  logic                       w_last;
  logic                       w_in_ready;
  logic                       w_start_acc;
  logic                       w_load_word;
  logic [7:0]                 w_byte [4];

  // Requested length clamped to the largest vector the SRAM holds.
  assign w_n = (len > MAX_N) ? MAX_N : len;

  // True in the UNPACK cycle that writes the final element.
  assign w_last = (r_cnt + 8'd1) == r_n;

  // Byte lanes of the buffered word; lane 0 goes to the lowest address.
  for (genvar gi = 0; gi < 4; gi++) begin : g_byte
    assign w_byte[gi] = r_wbuf[8*gi +: 8];
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state and handshake decode; in_ready depends only on state, bidx and cnt.
  always_comb begin
    w_state_next = r_state;
    w_in_ready   = 1'b0;
    w_start_acc  = 1'b0;
    w_load_word  = 1'b0;
    case (r_state)
      S_IDLE, S_DONE: begin
        if (start) begin
          w_start_acc  = 1'b1;
          w_state_next = (w_n == 8'd0) ? S_DONE : S_ACCEPT;
        end
      end
      S_ACCEPT: begin
        w_in_ready = 1'b1;
        if (in_valid) begin
          w_load_word  = 1'b1;
          w_state_next = S_UNPACK;
        end
      end
      S_UNPACK: begin
        if (w_last) begin
          // Any bytes left in the buffer past n are dropped.
          w_state_next = S_DONE;
        end else if (r_bidx == 2'd3) begin
          // Word exhausted: take the next one back-to-back if it is there.
          w_in_ready = 1'b1;
          if (in_valid) begin
            w_load_word  = 1'b1;
            w_state_next = S_UNPACK;
          end else begin
            w_state_next = S_ACCEPT;
          end
        end
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  // Datapath: length/count bookkeeping, word buffer and registered SRAM write port.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_n    <= '0;
      r_cnt  <= '0;
      r_bidx <= '0;
      r_wbuf <= '0;
      r_we   <= 1'b0;
      r_addr <= '0;
      r_din  <= '0;
    end else begin
      r_we <= 1'b0;
      if (w_start_acc) begin
        r_n   <= w_n;
        r_cnt <= '0;
      end
      if (r_state == S_UNPACK) begin
        r_we   <= 1'b1;
        r_addr <= SRAM_ADDR_WIDTH'(r_cnt);
        r_din  <= w_byte[r_bidx];
        r_cnt  <= r_cnt + 8'd1;
        r_bidx <= r_bidx + 2'd1;
      end
      // A freshly accepted word always starts at lane 0.
      if (w_load_word) begin
        r_wbuf <= in_data;
        r_bidx <= '0;
      end
    end
  end

  assign in_ready  = w_in_ready;
  assign sram_we   = r_we;
  assign sram_addr = r_addr;
  assign sram_din  = r_din;
  assign busy      = (r_state == S_ACCEPT) || (r_state == S_UNPACK);
  assign done      = (r_state == S_DONE);

endmodule
